spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 17 +
 rtl/spi_slave.sv | 201 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// Bus-side register interface for spi_slave.
//   CS      : peripheral select
//   REN/WEN : read / write enables
//   Addr    : byte address, registers decoded on Addr[11:2]
//   DataIn  : write data
//   DataOut : combinational read data
interface spi_slave_if;
  logic        CS;
  logic        REN;
  logic        WEN;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport slave  (input  CS, REN, WEN, Addr, DataIn, output DataOut);
  modport master (output CS, REN, WEN, Addr, DataIn, input  DataOut);
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 byte slave with a memory-mapped bus register file.
//   clk, rst            : system clock, asynchronous active-low reset
//   bus                 : register bus (spi_slave_if.slave)
//   spi_cs_in           : SPI chip select, active low, asynchronous to clk
//   spi_sclk_in         : SPI clock (mode 0, at most clk/8)
//   spi_mosi_in         : master-out data
//   spi_miso            : slave-out data, MSB first
//   irq                 : rx_valid AND irq_en
// Register map: 0x00 rx_data (R) / tx_data (W), 0x04 status (R),
//               0x08 control (W: bit0 clear errors, bit1 irq_en).
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  spi_slave_if.slave bus,
  input  logic       spi_cs_in,
  input  logic       spi_sclk_in,
  input  logic       spi_mosi_in,
  output logic       spi_miso,
  output logic       irq
);

  typedef enum logic {IDLE, SHIFT} state_t;

  // After reset the CS synchronizer holds its idle value (1); if the pin is
  // still low the pipeline flushes a spurious falling edge. Start detection
  // is ignored until that flush has completed.
  localparam int ARM_CYCLES = SYNC_STAGES + 1;

  logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
  logic                   r_cs_prev, r_sclk_prev;
  logic [2:0]             r_arm_cnt;

  state_t      r_state, w_state_next;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift, r_rx_data, r_tx_data, r_tx_shift;
  logic        r_rx_valid, r_tx_full, r_overrun, r_underrun, r_irq_en;
  logic        r_under_pend;

  logic        w_cs, w_mosi, w_armed;
  logic        w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  logic        w_load_start, w_reload, w_tx_shift, w_rx_sample, w_byte_done, w_leave;
  logic [9:0]  w_reg;
  logic        w_rd_rx, w_wr_tx, w_wr_ctrl;
  logic        w_overrun_set, w_underrun_set, w_err_clear;
  logic        w_unused;

  // ---------------- synchronizers and edge detect ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_prev   <= 1'b1;
      r_sclk_prev <= 1'b0;
      r_arm_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample its pre-edge
      // input, which is what makes this a shift chain rather than a wire.
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi_cs_in};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_in};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_in};
      r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 3'd1;
    end
  end

  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_armed     = (r_arm_cnt == 3'(ARM_CYCLES));
  assign w_cs_fall   =  r_cs_prev & ~w_cs;
  assign w_cs_rise   = ~r_cs_prev &  w_cs;
  assign w_sclk_rise = ~r_sclk_prev &  r_sclk_sync[SYNC_STAGES-1];
  assign w_sclk_fall =  r_sclk_prev & ~r_sclk_sync[SYNC_STAGES-1];

  // ---------------- bus decode ----------------
  assign w_reg     = bus.Addr[11:2];
  assign w_rd_rx   = bus.CS & bus.REN & (w_reg == 10'd0);
  assign w_wr_tx   = bus.CS & bus.WEN & (w_reg == 10'd0);
  assign w_wr_ctrl = bus.CS & bus.WEN & (w_reg == 10'd2);
  assign w_unused  = ^{bus.Addr[1:0], bus.DataIn[31:8]};

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    w_state_next = r_state;
    w_load_start = 1'b0;
    w_reload     = 1'b0;
    w_tx_shift   = 1'b0;
    w_rx_sample  = 1'b0;
    w_byte_done  = 1'b0;
    w_leave      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cs_fall && w_armed) begin
          w_state_next = SHIFT;
          w_load_start = 1'b1;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_state_next = IDLE;
          w_leave      = 1'b1;
        end else if (w_sclk_rise) begin
          w_rx_sample = 1'b1;
          w_byte_done = (r_bit_cnt == 3'd7);
        end else if (w_sclk_fall) begin
          if (r_bit_cnt != 3'd0) w_tx_shift = 1'b1;
          else                   w_reload   = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  // A reload on the last falling edge of a byte happens even if CS is about
  // to rise, so an empty TX buffer there only counts as underrun once the
  // next byte actually starts clocking (r_under_pend).
  assign w_underrun_set = (w_load_start && !r_tx_full) || (w_rx_sample && r_under_pend);
  assign w_overrun_set  = w_byte_done && r_rx_valid && !w_rd_rx;
  assign w_err_clear    = w_wr_ctrl && bus.DataIn[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt    <= '0;
      r_rx_shift   <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_tx_shift   <= '0;
      r_tx_full    <= 1'b0;
      r_overrun    <= 1'b0;
      r_underrun   <= 1'b0;
      r_irq_en     <= 1'b0;
      r_under_pend <= 1'b0;
    end else begin
      if (w_leave || w_load_start) r_bit_cnt <= '0;
      else if (w_rx_sample)        r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_rx_sample) r_rx_shift <= {r_rx_shift[6:0], w_mosi};

      // A byte completing alongside a read of rx_data replaces it cleanly.
      if (w_byte_done && (!r_rx_valid || w_rd_rx)) begin
        r_rx_data  <= {r_rx_shift[6:0], w_mosi};
        r_rx_valid <= 1'b1;
      end else if (w_rd_rx) begin
        r_rx_valid <= 1'b0;
      end

      if (w_load_start || w_reload) r_tx_shift <= r_tx_full ? r_tx_data : 8'h00;
      else if (w_tx_shift)          r_tx_shift <= {r_tx_shift[6:0], 1'b0};

      // A bus write beats a same-cycle load: the old byte goes out, the new
      // one stays pending.
      if (w_wr_tx) begin
        r_tx_data <= bus.DataIn[7:0];
        r_tx_full <= 1'b1;
      end else if (w_load_start || w_reload) begin
        r_tx_full <= 1'b0;
      end

      if (w_reload)                                 r_under_pend <= ~r_tx_full;
      else if (w_rx_sample || w_leave || w_load_start) r_under_pend <= 1'b0;

      if (w_overrun_set)    r_overrun <= 1'b1;
      else if (w_err_clear) r_overrun <= 1'b0;

      if (w_underrun_set)   r_underrun <= 1'b1;
      else if (w_err_clear) r_underrun <= 1'b0;

      if (w_wr_ctrl) r_irq_en <= bus.DataIn[1];
    end
  end

  // ---------------- outputs ----------------
  assign spi_miso = (r_state == SHIFT) ? r_tx_shift[7] : 1'b0;
  assign irq      = r_rx_valid & r_irq_en;

  always_comb begin
    bus.DataOut = '0;
    if (bus.CS && bus.REN) begin
      case (w_reg)
        10'd0:   bus.DataOut = {24'd0, r_rx_data};
        10'd1:   bus.DataOut = {27'd0, r_underrun, r_overrun, r_tx_full,
                                (r_state == SHIFT), r_rx_valid};
        10'd2:   bus.DataOut = {30'd0, r_irq_en, 1'b0};
        default: bus.DataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: stimulus tasks update a transaction-level
// model and queue expected MISO bits / bus read data; two monitors compare
// whenever the DUT presents a MISO bit or read data.
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst;
  logic spi_cs, spi_sclk, spi_mosi;
  logic spi_miso, irq;

  spi_slave_if bus ();

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .spi_cs_in   (spi_cs),
    .spi_sclk_in (spi_sclk),
    .spi_mosi_in (spi_mosi),
    .spi_miso    (spi_miso),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic       m_tx_full, m_rx_valid, m_overrun, m_underrun, m_irq_en, m_active;
  logic [7:0] m_tx_data, m_rx_data;

  logic        exp_miso_q[$];
  logic [31:0] exp_rd_q[$];
  string       rd_name_q[$];
  logic [7:0]  frame_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tx_full = 0; m_rx_valid = 0; m_overrun = 0; m_underrun = 0;
    m_irq_en = 0; m_active = 0; m_tx_data = 0; m_rx_data = 0;
  endtask

  function automatic logic [31:0] model_rd(input logic [11:0] a);
    case (a[11:2])
      10'd0:   return {24'd0, m_rx_data};
      10'd1:   return {27'd0, m_underrun, m_overrun, m_tx_full, m_active, m_rx_valid};
      10'd2:   return {30'd0, m_irq_en, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- monitors ----------------
  always @(posedge spi_sclk) begin
    if (!spi_cs) begin
      if (exp_miso_q.size() == 0) begin
        total++; bad++;
        $display("FAIL miso_unexpected: got %b expected no bit", spi_miso);
      end else begin
        check("miso_bit", 32'(spi_miso), 32'(exp_miso_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.CS && bus.REN) begin
      if (exp_rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL read_unexpected: got %h expected no read", bus.DataOut);
      end else begin
        check(rd_name_q.pop_front(), bus.DataOut, exp_rd_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    bus.CS = 1; bus.WEN = 1; bus.Addr = a; bus.DataIn = d;
    tick(1);
    bus.CS = 0; bus.WEN = 0;
    if (a[11:2] == 10'd0) begin
      m_tx_full = 1; m_tx_data = d[7:0];
    end else if (a[11:2] == 10'd2) begin
      if (d[0]) begin m_overrun = 0; m_underrun = 0; end
      m_irq_en = d[1];
    end
  endtask

  task automatic bus_read(input logic [11:0] a, input string nm);
    exp_rd_q.push_back(model_rd(a));
    rd_name_q.push_back(nm);
    bus.CS = 1; bus.REN = 1; bus.Addr = a;
    tick(1);
    bus.CS = 0; bus.REN = 0;
    if (a[11:2] == 10'd0) m_rx_valid = 0;
  endtask

  task automatic sclk_bit(input logic mosi, input logic exp_miso);
    spi_mosi = mosi;
    exp_miso_q.push_back(exp_miso);
    tick(4); spi_sclk = 1; tick(8); spi_sclk = 0; tick(4);
  endtask

  // Sends nbits from frame_q (MSB first) inside one CS-low window.
  task automatic spi_frame(input int nbits);
    logic [7:0] mb, db;
    logic       pend;
    int         n, k, left;
    spi_cs = 0; m_active = 1;
    tick(6);
    if (m_tx_full) begin mb = m_tx_data; m_tx_full = 0; end
    else begin mb = 8'h00; m_underrun = 1; end
    pend = 0; k = 0; left = nbits;
    while (left > 0) begin
      db = frame_q[k];
      n  = (left > 8) ? 8 : left;
      if (pend) m_underrun = 1;
      for (int i = 0; i < n; i++) sclk_bit(db[7-i], mb[7-i]);
      if (n == 8) begin
        if (m_rx_valid) m_overrun = 1;
        else begin m_rx_data = db; m_rx_valid = 1; end
        if (m_tx_full) begin mb = m_tx_data; m_tx_full = 0; pend = 0; end
        else begin mb = 8'h00; pend = 1; end
      end
      left -= n; k++;
    end
    spi_mosi = 0; tick(4);
    spi_cs = 1; tick(8);
    m_active = 0;
    frame_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 0; spi_cs = 1; spi_sclk = 0; spi_mosi = 0;
    bus.CS = 0; bus.REN = 0; bus.WEN = 0; bus.Addr = '0; bus.DataIn = '0;
    tick(3);
    check("reset_miso", 32'(spi_miso), 32'd0);
    check("reset_irq",  32'(irq),      32'd0);
    rst = 1;
    tick(6);
    bus_read(12'h000, "reset_rx_data");
    bus_read(12'h004, "reset_status");
    bus_read(12'h008, "reset_ctrl");

    // TX 0xA5 while receiving 0x3C
    bus_write(12'h000, 32'hA5);
    bus_read(12'h004, "tx_full_status");
    frame_q.push_back(8'h3C);
    spi_frame(8);
    bus_read(12'h004, "a5_status");
    bus_read(12'h000, "a5_rx_data");
    bus_read(12'h004, "a5_status_after_read");

    // Two bytes, no read in between -> overrun; then clear
    frame_q.push_back(8'h11); frame_q.push_back(8'h22);
    spi_frame(16);
    bus_read(12'h004, "overrun_status");
    bus_read(12'h000, "overrun_rx_data");
    bus_write(12'h008, 32'h1);
    bus_read(12'h004, "cleared_status");

    // Frame without TX data -> underrun
    frame_q.push_back(8'hE7);
    spi_frame(8);
    bus_read(12'h004, "underrun_status");
    bus_read(12'h000, "underrun_rx_data");
    bus_write(12'h008, 32'h1);

    // Aborted frame after 5 bits, then 0x81
    bus_write(12'h000, 32'h96);
    frame_q.push_back(8'hFF);
    spi_cs = 0; m_active = 1; tick(6);
    m_tx_full = 0;
    bus_read(12'h004, "active_status");
    for (int i = 0; i < 5; i++) sclk_bit(1'b1, 8'h96 >> (7 - i));
    tick(4); spi_cs = 1; tick(8); m_active = 0; frame_q.delete();
    bus_read(12'h004, "abort_status");
    bus_write(12'h000, 32'h5C);
    frame_q.push_back(8'h81);
    spi_frame(8);
    bus_read(12'h000, "abort_next_rx_data");
    bus_read(12'h004, "abort_next_status");

    // Interrupt
    bus_write(12'h008, 32'h2);
    frame_q.push_back(8'h4D);
    spi_frame(8);
    check("irq_set", 32'(irq), 32'd1);
    bus.CS = 1; bus.REN = 0; bus.Addr = 12'h000; #1;
    check("no_ren_dataout", bus.DataOut, 32'd0);
    bus.CS = 0;
    bus_read(12'h00C, "unmapped_read");
    bus_read(12'h008, "ctrl_read");
    bus_read(12'h000, "irq_rx_data");
    check("irq_clear", 32'(irq), 32'd0);
    bus_write(12'h008, 32'h0);

    // Reset mid-frame
    bus_write(12'h000, 32'hC3);
    spi_cs = 0; tick(6);
    for (int i = 0; i < 3; i++) sclk_bit(1'b0, 8'hC3 >> (7 - i));
    rst = 0; model_reset(); #1;
    check("midrst_miso", 32'(spi_miso), 32'd0);
    check("midrst_irq",  32'(irq),      32'd0);
    bus_read(12'h004, "midrst_status");
    bus_read(12'h000, "midrst_rx_data");
    rst = 1;
    for (int i = 0; i < 3; i++) sclk_bit(1'b1, 1'b0);
    tick(4); spi_cs = 1; tick(8);
    bus_read(12'h004, "post_rst_status");
    frame_q.push_back(8'h5A);
    spi_frame(8);
    bus_read(12'h000, "post_rst_rx_data");
    bus_write(12'h008, 32'h1);

    // Randomized traffic
    for (int it = 0; it < 16; it++) begin
      int nb;
      if ($urandom_range(0, 1) == 1) bus_write(12'h000, 32'($urandom_range(0, 255)));
      nb = $urandom_range(1, 2);
      for (int j = 0; j < nb; j++) frame_q.push_back(8'($urandom_range(0, 255)));
      spi_frame(nb * 8);
      bus_read(12'h004, "rand_status");
      if ($urandom_range(0, 2) != 0) bus_read(12'h000, "rand_rx_data");
      if ($urandom_range(0, 3) == 0) bus_write(12'h008, 32'($urandom_range(0, 3)));
      check("rand_irq", 32'(irq), 32'(m_rx_valid & m_irq_en));
    end

    check("miso_queue_drained", 32'(exp_miso_q.size()), 32'd0);
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
